// File: rtl/clk_div_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The controller (master) drives enables, sync and loads; the divider answers.
interface clk_div_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 28
);
  logic [CHANNELS-1:0]       en;
  logic                      sync;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] div_in;
  logic [CHANNELS*WIDTH-1:0] high_in;
  logic [CHANNELS-1:0]       load_ack;
  logic [CHANNELS-1:0]       clock_out;
  logic [CHANNELS-1:0]       tick;

  modport master (
    output en, sync, load, div_in, high_in,
    input  load_ack, clock_out, tick
  );

  modport slave (
    input  en, sync, load, div_in, high_in,
    output load_ack, clock_out, tick
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free
// period/high-time reload at period boundaries and global phase sync.
module clk_div_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(5000000),
  parameter logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input logic          clk,
  input logic          rst_n,
  clk_div_multi_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [CHANNELS-1:0] co;
  logic [CHANNELS-1:0] tk;
  logic [CHANNELS-1:0] ack;

  assign bus.clock_out = co;
  assign bus.tick      = tk;
  assign bus.load_ack  = ack;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] high_pend;
    logic [WIDTH-1:0] div_new;
    logic [WIDTH-1:0] high_new;
    logic             pend;
    logic             en_i;
    logic             wrap;
    logic             apply;
    logic             co_q;
    logic             tk_q;
    logic             ack_q;

    assign en_i  = bus.en[i];
    assign wrap  = en_i && (cnt == div_act - ONE);
    assign apply = wrap || !en_i || bus.sync;

    // Clamp on capture so the active pair is always legal.
    always_comb begin
      div_new  = bus.div_in[i*WIDTH +: WIDTH];
      high_new = bus.high_in[i*WIDTH +: WIDTH];
      if (div_new < TWO) div_new = TWO;
      if (high_new > div_new) high_new = div_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        div_act   <= DEFAULT_DIV;
        high_act  <= DEFAULT_HIGH;
        div_pend  <= DEFAULT_DIV;
        high_pend <= DEFAULT_HIGH;
        pend      <= 1'b0;
        co_q      <= 1'b0;
        tk_q      <= 1'b0;
        ack_q     <= 1'b0;
      end else begin
        if (bus.sync || !en_i) begin
          cnt  <= '0;
          co_q <= 1'b0;
          tk_q <= 1'b0;
        end else begin
          cnt  <= wrap ? '0 : cnt + ONE;
          co_q <= cnt < high_act;
          tk_q <= wrap;
        end
        ack_q <= 1'b0;
        // A load on an apply edge skips the pending stage.
        if (bus.load[i] && apply) begin
          div_act  <= div_new;
          high_act <= high_new;
          pend     <= 1'b0;
          ack_q    <= 1'b1;
        end else if (bus.load[i]) begin
          div_pend  <= div_new;
          high_pend <= high_new;
          pend      <= 1'b1;
        end else if (pend && apply) begin
          div_act  <= div_pend;
          high_act <= high_pend;
          pend     <= 1'b0;
          ack_q    <= 1'b1;
        end
      end
    end

    assign co[i]  = co_q;
    assign tk[i]  = tk_q;
    assign ack[i] = ack_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: random and directed stimulus
// against a cycle-level phase model of each divider channel.
module tb_clk_div_multi;
  localparam int CH = 2;
  localparam int W  = 8;

  typedef struct {
    logic [CH-1:0] co;
    logic [CH-1:0] tk;
    logic [CH-1:0] ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  clk_div_multi #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_DIV(8'd10),
    .DEFAULT_HIGH(8'd5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Model: position within the current period plus active/pending settings.
  int  pos[CH];
  int  per[CH];
  int  hi[CH];
  int  pper[CH];
  int  phi[CH];
  bit  pend[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      pos[c] = 0; per[c] = 10; hi[c] = 5;
      pper[c] = 10; phi[c] = 5; pend[c] = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (bus.clock_out !== x.co || bus.tick !== x.tk ||
          bus.load_ack !== x.ack) begin
        errors++;
        $display("FAIL outputs t=%0t co/tk/ack got %b/%b/%b want %b/%b/%b",
                 $time, bus.clock_out, bus.tick, bus.load_ack,
                 x.co, x.tk, x.ack);
      end
    end
  end

  task automatic step(input logic [CH-1:0] e, input logic s,
                      input logic [CH-1:0] l,
                      input int d0, input int h0,
                      input int d1, input int h1);
    int   d[CH];
    int   h[CH];
    exp_t x;
    @(negedge clk);
    #1;
    d[0] = d0; h[0] = h0; d[1] = d1; h[1] = h1;
    bus.en = e;
    bus.sync = s;
    bus.load = l;
    bus.div_in = {W'(d1), W'(d0)};
    bus.high_in = {W'(h1), W'(h0)};
    for (int c = 0; c < CH; c++) begin
      bit running, at_end, boundary;
      int nd, nh;
      running  = e[c] && !s;
      at_end   = e[c] && (pos[c] == per[c] - 1);
      boundary = at_end || !e[c] || s;
      x.co[c]  = running && (pos[c] < hi[c]);
      x.tk[c]  = running && at_end;
      x.ack[c] = 1'b0;
      nd = (d[c] < 2) ? 2 : d[c];
      nh = (h[c] > nd) ? nd : h[c];
      if (l[c] && boundary) begin
        per[c] = nd; hi[c] = nh; pend[c] = 0; x.ack[c] = 1'b1;
      end else if (l[c]) begin
        pper[c] = nd; phi[c] = nh; pend[c] = 1;
      end else if (pend[c] && boundary) begin
        per[c] = pper[c]; hi[c] = phi[c]; pend[c] = 0; x.ack[c] = 1'b1;
      end
      pos[c] = (running && !at_end) ? pos[c] + 1 : 0;
    end
    q.push_back(x);
  endtask

  task automatic run(input int n, input logic [CH-1:0] e);
    repeat (n) step(e, 1'b0, '0, 0, 0, 0, 0);
  endtask

  task automatic hold_reset(input int n);
    exp_t x;
    repeat (n) begin
      @(negedge clk);
      #1;
      bus.en = 2'b11;
      bus.load = 2'($urandom);
      bus.sync = 1'b0;
      bus.div_in = 16'($urandom);
      bus.high_in = 16'($urandom);
      x.co = '0; x.tk = '0; x.ack = '0;
      q.push_back(x);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.load = '0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clock_out !== '0 || bus.tick !== '0 || bus.load_ack !== '0) begin
      errors++;
      $display("FAIL async_reset co/tk/ack got %b/%b/%b want 00/00/00",
               bus.clock_out, bus.tick, bus.load_ack);
    end
    model_reset();
    hold_reset(2);
  endtask

  initial begin
    bus.en = 2'b11;
    bus.sync = 1'b0;
    bus.load = '0;
    bus.div_in = '0;
    bus.high_in = '0;
    model_reset();
    hold_reset(3);

    // Defaults: 5 high / 5 low, tick every 10.
    run(25, 2'b11);

    // Runtime load mid-period.
    step(2'b11, 0, 2'b01, 4, 2, 0, 0);
    run(9, 2'b11);
    step(2'b11, 0, 2'b01, 6, 1, 0, 0);
    run(15, 2'b11);

    // Last-wins with clamping, then div=0.
    step(2'b11, 0, 2'b01, 8, 4, 0, 0);
    step(2'b11, 0, 2'b01, 3, 7, 0, 0);
    run(12, 2'b11);
    step(2'b11, 0, 2'b10, 0, 0, 0, 1);
    run(12, 2'b11);

    // Sync two channels of different period.
    step(2'b11, 0, 2'b11, 5, 2, 7, 3);
    run(20, 2'b11);
    step(2'b11, 1, 2'b00, 0, 0, 0, 0);
    run(40, 2'b11);

    // Load while disabled, drop and restore enable.
    step(2'b01, 0, 2'b10, 4, 1, 9, 4);
    run(5, 2'b01);
    run(7, 2'b11);
    run(2, 2'b10);
    run(8, 2'b11);

    // Async reset with a load pending.
    step(2'b11, 0, 2'b01, 12, 3, 0, 0);
    async_reset();
    run(22, 2'b11);

    repeat (1500) begin
      logic [CH-1:0] e;
      e[0] = ($urandom_range(0, 15) != 0);
      e[1] = ($urandom_range(0, 15) != 0);
      step(e, ($urandom_range(0, 60) == 0),
           {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
           $urandom_range(0, 12), $urandom_range(0, 14),
           $urandom_range(0, 12), $urandom_range(0, 14));
    end

    async_reset();
    run(15, 2'b11);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
